// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared widths, control-bundle bit map and stage state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 14;

    // Control bundle layout, MSB first
    localparam int c_CTRL_BRANCH    = 13;
    localparam int c_CTRL_MEMREAD   = 12;
    localparam int c_CTRL_MEMWRITE  = 11;
    localparam int c_CTRL_MEMTOREG  = 10;
    localparam int c_CTRL_REGWRITE  = 9;
    localparam int c_CTRL_ALUSRC    = 8;
    localparam int c_CTRL_ALUOP_MSB = 7;
    localparam int c_CTRL_ALUOP_LSB = 4;
    localparam int c_CTRL_FUNCT_MSB = 3;
    localparam int c_CTRL_FUNCT_LSB = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Two-entry skid-buffered pipeline register with flush and
//               NOP gating of the control bundle on bubbles
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
    parameter int DATA_W = pipe_pkg::DATA_W,
    parameter int NDATA  = 4,
    parameter int REG_W  = pipe_pkg::REG_W,
    parameter int NREG   = 3,
    parameter int CTRL_W = pipe_pkg::CTRL_W
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NREG*REG_W-1:0]   in_regs,
    input  logic [NDATA*DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NREG*REG_W-1:0]   out_regs,
    output logic [NDATA*DATA_W-1:0] out_data,
    output logic [1:0]              occupancy
);

    import pipe_pkg::*;

    localparam int c_REGS_W  = NREG * REG_W;
    localparam int c_DATAS_W = NDATA * DATA_W;
    localparam int c_ENTRY_W = CTRL_W + c_REGS_W + c_DATAS_W;

    stage_state_e           r_state;
    stage_state_e           w_state_nxt;
    logic [c_ENTRY_W-1:0]   r_main;
    logic [c_ENTRY_W-1:0]   r_skid;
    logic [c_ENTRY_W-1:0]   w_in_entry;
    logic                   w_in_xfer;
    logic                   w_out_xfer;
    logic                   w_load_main_in;
    logic                   w_load_main_skid;
    logic                   w_load_skid;

    assign w_in_entry = {in_ctrl, in_regs, in_data};

    // Ready is a pure state decode so no combinational path exists from out_ready
    assign in_ready   = (r_state != FULL);
    assign out_valid  = (r_state == ONE) || (r_state == FULL);
    assign occupancy  = r_state;
    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) begin
                    w_load_main_in = 1'b1;
                    w_state_nxt    = ONE;
                end
            end
            ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_xfer) begin
                    w_load_skid = 1'b1;
                    w_state_nxt = FULL;
                end else if (w_out_xfer) begin
                    w_state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (w_out_xfer) begin
                    w_load_main_skid = 1'b1;
                    w_state_nxt      = ONE;
                end
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush drops everything held plus any entry offered this cycle
        if (flush) begin
            w_state_nxt      = EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_main_in) begin
                r_main <= w_in_entry;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    // Bubbles present as NOPs downstream; payload keeps the last main value
    assign out_ctrl = out_valid ? r_main[c_ENTRY_W-1 -: CTRL_W] : '0;
    assign out_regs = r_main[c_DATAS_W +: c_REGS_W];
    assign out_data = r_main[0 +: c_DATAS_W];

endmodule : pipe_stage_skid
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

    localparam int c_DATA_W = 64;
    localparam int c_NDATA  = 4;
    localparam int c_REG_W  = 5;
    localparam int c_NREG   = 3;
    localparam int c_CTRL_W = 14;

    logic                          clk;
    logic                          reset_n;
    logic                          flush;
    logic                          in_valid;
    logic                          in_ready;
    logic [c_CTRL_W-1:0]           in_ctrl;
    logic [c_NREG*c_REG_W-1:0]     in_regs;
    logic [c_NDATA*c_DATA_W-1:0]   in_data;
    logic                          out_valid;
    logic                          out_ready;
    logic [c_CTRL_W-1:0]           out_ctrl;
    logic [c_NREG*c_REG_W-1:0]     out_regs;
    logic [c_NDATA*c_DATA_W-1:0]   out_data;
    logic [1:0]                    occupancy;

    int n_checks = 0;
    int n_errors = 0;

    pipe_stage_skid #(
        .DATA_W (c_DATA_W),
        .NDATA  (c_NDATA),
        .REG_W  (c_REG_W),
        .NREG   (c_NREG),
        .CTRL_W (c_CTRL_W)
    ) u_dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_regs   (in_regs),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_regs  (out_regs),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Payload of entry v: lane0 = v, lane3 = ~v, ctrl/regs = low bits of v
    function automatic logic [255:0] mk_data(input logic [31:0] v);
        logic [255:0] d;
        d          = '0;
        d[63:0]    = {32'h0, v};
        d[255:192] = {32'hFFFF_FFFF, ~v};
        return d;
    endfunction

    task automatic drive(input logic [31:0] v);
        in_valid = 1'b1;
        in_data  = mk_data(v);
        in_ctrl  = v[13:0];
        in_regs  = v[14:0];
    endtask

    task automatic expect_entry(input string tag, input logic [31:0] v);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_data"}, out_data, mk_data(v));
        check({tag, "_ctrl"}, out_ctrl, v[13:0]);
        check({tag, "_regs"}, out_regs, v[14:0]);
    endtask

    initial begin
        logic [255:0] q[$];
        int seq, popped, cnt, cyc;
        bit in_x, out_x;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_regs   = '0;
        in_data   = '0;
        #2;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_ctrl", out_ctrl, 14'd0);
        check("rst_out_regs", out_regs, 15'd0);
        check("rst_out_data", out_data, 256'd0);
        check("rst_occ", occupancy, 2'd0);
        tick();
        reset_n = 1'b1;

        // First entry after reset, one cycle latency
        in_valid  = 1'b1;
        in_data   = '0;
        in_data[63:0] = 64'h1000;
        in_ctrl   = 14'h3FFF;
        in_regs   = 15'h0;
        out_ready = 1'b1;
        tick();
        check("first_valid", out_valid, 1'b1);
        check("first_lane0", out_data[63:0], 64'h1000);
        check("first_ctrl", out_ctrl, 14'h3FFF);
        check("first_occ", occupancy, 2'd1);
        in_valid = 1'b0;
        tick();
        check("drain_valid", out_valid, 1'b0);
        check("drain_ctrl_gated", out_ctrl, 14'd0);
        check("drain_data_hold", out_data[63:0], 64'h1000);
        check("drain_occ", occupancy, 2'd0);

        // Back-pressure: A, B fill; C waits at input
        out_ready = 1'b0;
        drive(32'h11);
        tick();
        check("bp_occ1", occupancy, 2'd1);
        drive(32'h22);
        tick();
        check("bp_occ2", occupancy, 2'd2);
        check("bp_in_ready", in_ready, 1'b0);
        drive(32'h33);
        tick();
        check("bp_occ_hold", occupancy, 2'd2);
        expect_entry("bp_A", 32'h11);
        out_ready = 1'b1;
        tick();
        expect_entry("bp_B", 32'h22);
        check("bp_occ_B", occupancy, 2'd1);
        tick();
        expect_entry("bp_C", 32'h33);
        in_valid = 1'b0;
        tick();
        check("bp_empty", occupancy, 2'd0);

        // Flush while FULL with a simultaneous offer
        out_ready = 1'b0;
        drive(32'h11);
        tick();
        drive(32'h22);
        tick();
        check("fl_full", occupancy, 2'd2);
        flush = 1'b1;
        drive(32'h44);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        check("fl_occ", occupancy, 2'd0);
        check("fl_valid", out_valid, 1'b0);
        check("fl_ctrl", out_ctrl, 14'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_stay_empty", out_valid, 1'b0);
            check("fl_no_44", out_data[63:0], 64'h11);
        end

        // Streaming 0..99 at full rate
        out_ready = 1'b1;
        drive(32'd0);
        tick();
        for (int i = 1; i < 100; i++) begin
            expect_entry("str", i - 1);
            check("str_in_ready", in_ready, 1'b1);
            drive(i);
            tick();
        end
        expect_entry("str_last", 32'd99);
        in_valid = 1'b0;
        tick();
        check("str_empty", occupancy, 2'd0);

        // Asynchronous reset mid-cycle while FULL
        out_ready = 1'b0;
        drive(32'h55);
        tick();
        drive(32'h66);
        tick();
        in_valid = 1'b0;
        check("ar_full", occupancy, 2'd2);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_valid", out_valid, 1'b0);
        check("ar_occ", occupancy, 2'd0);
        check("ar_in_ready", in_ready, 1'b1);
        check("ar_ctrl", out_ctrl, 14'd0);
        check("ar_data", out_data, 256'd0);
        @(negedge clk);
        reset_n = 1'b1;
        out_ready = 1'b1;
        drive(32'h77);
        tick();
        expect_entry("ar_after", 32'h77);
        in_valid = 1'b0;
        tick();
        check("ar_drain", occupancy, 2'd0);

        // Random handshakes against a queue model
        seq = 1000; popped = 0; cnt = 0; cyc = 0;
        while (popped < 10000 && cyc < 60000) begin
            in_valid  = 1'b0;
            if ($urandom_range(0, 1) == 1) drive(seq);
            out_ready = ($urandom_range(0, 1) == 1);
            check("rnd_in_ready", in_ready, (cnt < 2));
            check("rnd_valid", out_valid, (cnt > 0));
            if (cnt > 0) begin
                check("rnd_data", out_data, q[0]);
                check("rnd_ctrl", out_ctrl, q[0][13:0]);
            end else begin
                check("rnd_ctrl_nop", out_ctrl, 14'd0);
            end
            out_x = (cnt > 0) && out_ready;
            in_x  = in_valid && (cnt < 2);
            if (out_x) begin
                void'(q.pop_front());
                popped++;
            end
            if (in_x) begin
                q.push_back(mk_data(seq));
                seq++;
            end
            cnt = cnt + int'(in_x) - int'(out_x);
            tick();
            cyc++;
        end
        check("rnd_count", popped, 10000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_pipe_stage_skid
`default_nettype wire

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  DATA_W, 64, width of one data lane (PC, operand, immediate)
  NDATA, 4, number of data lanes
  REG_W, 5, width of one register-index field
  NREG, 3, number of register-index fields (rs1, rs2, rd)
  CTRL_W, 14, width of packed control bundle (Branch, MemRead, MemWrite, MemtoReg, RegWrite, ALUSrc, ALUOp[3:0], Funct[3:0])
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
  clk  in  1  single clock, all state on rising edge
  reset_n  in  1  asynchronous, active-low reset
  flush  in  1  synchronous squash of all held entries
  in_valid  in  1  upstream entry present
  in_ready  out  1  stage can accept an entry this cycle
  in_ctrl  in  CTRL_W  control bundle
  in_regs  in  NREG*REG_W  register indices
  in_data  in  NDATA*DATA_W  data lanes
  out_valid  out  1  output entry present
  out_ready  in  1  downstream accepts output entry this cycle
  out_ctrl  out  CTRL_W  control bundle, zero when out_valid=0
  out_regs  out  NREG*REG_W  register indices
  out_data  out  NDATA*DATA_W  data lanes
  occupancy  out  2  held entries (0, 1 or 2)

Function
REQ-003 SHALL hold two entries: main (drives outputs) and skid; state EMPTY, ONE, FULL.
REQ-004 SHALL treat a transfer in as in_valid&in_ready and a transfer out as out_valid&out_ready, both sampled at rising clk.
REQ-005 SHALL drive in_ready=1 in EMPTY and ONE, 0 in FULL, decoded from state only (no combinational path from out_ready).
REQ-006 SHALL drive out_valid=1 in ONE and FULL; occupancy = 0/1/2 for EMPTY/ONE/FULL.
REQ-007 EMPTY: transfer in -> main loads input, go ONE; else stay.
REQ-008 ONE: in & out -> main reloads input, stay ONE; in only -> skid loads input, go FULL; out only -> go EMPTY; neither -> hold.
REQ-009 FULL: out -> main loads skid, go ONE; else hold; input ignored.
REQ-010 Latency SHALL be exactly one cycle from transfer in to out_valid when EMPTY; order SHALL be preserved, no entry dropped or duplicated absent flush.
REQ-011 flush=1 SHALL force EMPTY next cycle, overriding any simultaneous transfer in (input discarded); the cycle's transfer out still counts as consumed.
REQ-012 out_ctrl SHALL be gated to all-zero whenever out_valid=0 (bubble = NOP); out_data/out_regs SHALL hold last main value when invalid.
REQ-013 Entry fields SHALL pass bit-exact; no arithmetic, no width conversion.

Reset
REQ-014 reset_n low SHALL asynchronously force EMPTY, all main/skid fields to zero, so out_valid=0, in_ready=1, out_ctrl=0, out_regs=0, out_data=0, occupancy=0.
REQ-015 Reset asserted mid-operation SHALL discard both entries; first transfer in after release SHALL appear one cycle later.

Structure
REQ-016 Shared package pipe_pkg SHALL hold default widths (DATA_W, REG_W, CTRL_W), control-bundle bit positions and the 2-bit state enum (EMPTY=0, ONE=1, FULL=2).
REQ-017 SHALL be a single module, no sub-modules; one sequential block for state/entries, combinational output gating.

Verification
REQ-018 Reset release, in_valid=1, in_data lane0=0x1000, in_ctrl=0x3FFF, out_ready=1 -> next cycle out_valid=1, out_data lane0=0x1000, out_ctrl=0x3FFF, occupancy=1.
REQ-019 out_ready=0, push A=0x11, B=0x22 back-to-back -> occupancy=2, in_ready=0; C=0x33 offered is not taken; out_ready=1 -> outputs A, B, C in order on successive cycles.
REQ-020 FULL with A/B held, flush=1 with in_valid=1 (0x44) -> next cycle occupancy=0, out_valid=0, out_ctrl=0; 0x44 never appears.
REQ-021 Continuous in_valid=1, out_ready=1, 100 incrementing values 0..99 -> outputs 0..99, in_ready constantly 1, throughput 1/cycle.
REQ-022 reset_n low while FULL, mid-cycle -> immediately out_valid=0, occupancy=0, in_ready=1 without a clock edge.
REQ-023 Random in_valid/out_ready (50%), scoreboard compare 10k entries -> no loss, duplication or reordering; out_ctrl=0 whenever out_valid=0.
